// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - redirect, instruction-memory and decode signals of the fetch queue
interface ifetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect;
  logic [31:0]   redirect_addr;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          inst_valid;
  logic [31:0]   inst_word;
  logic [31:0]   inst_pc;
  logic          inst_ready;
  logic [CW-1:0] fq_count;

  // Fetch-queue side
  modport master (
    input  redirect, redirect_addr, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_word, inst_pc, fq_count
  );

  // Environment side: PC logic, instruction memory and decode
  modport slave (
    output redirect, redirect_addr, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_word, inst_pc, fq_count
  );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue: imem req/ack fetcher feeding a PC-tagged FIFO
// Optional macro IFQ_BYPASS_EN: forward an ack word straight to decode when the FIFO is empty.
module ifetch_queue #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  ifetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state_q;
  logic          imem_req_q;
  logic [31:0]   imem_addr_q;
  logic [31:0]   fetch_ptr_q, fetch_ptr_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic head_valid;
  logic bypass_hit;
  logic bypass_take;
  logic accept;
  logic push;
  logic pop;
  logic space;

  // Per-cycle decisions: what is accepted, pushed, popped, and where fetching continues
  always_comb begin
    head_valid  = (count_q != '0);
    bypass_hit  = 1'b0;
`ifdef IFQ_BYPASS_EN
    bypass_hit  = !head_valid && (state_q == WAIT) && bus.imem_ack && !bus.redirect;
`endif
    bypass_take = bypass_hit && bus.inst_ready;
    // Redirect voids both the same-cycle pop and the returning word
    pop         = head_valid && bus.inst_ready && !bus.redirect;
    accept      = (state_q == WAIT) && bus.imem_ack && !bus.redirect;
    push        = accept && !bypass_take;

    fetch_ptr_d = fetch_ptr_q;
    if (bus.redirect) begin
      fetch_ptr_d = {bus.redirect_addr[31:2], 2'b00};
    end else if (accept) begin
      fetch_ptr_d = fetch_ptr_q + 32'd4;
    end

    if (bus.redirect) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
    // A request may only go out if its word is guaranteed a slot
    space = (count_d < FULL);
  end

  // Fetch FSM: owns the request handshake and the fetch pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_ADDR;
      fetch_ptr_q <= RESET_ADDR;
    end else begin
      fetch_ptr_q <= fetch_ptr_d;
      case (state_q)
        IDLE: begin
          if (space) begin
            state_q     <= WAIT;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_ptr_d;
          end
        end
        WAIT: begin
          if (bus.imem_ack) begin
            if (space) begin
              imem_addr_q <= fetch_ptr_d;
            end else begin
              state_q    <= IDLE;
              imem_req_q <= 1'b0;
            end
          end else if (bus.redirect) begin
            // Request cannot be withdrawn; keep it up and drop its data later
            state_q <= DISCARD;
          end
        end
        DISCARD: begin
          if (bus.imem_ack) begin
            state_q     <= WAIT;
            imem_addr_q <= fetch_ptr_d;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // PC-tagged FIFO storage and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      count_q <= count_d;
      if (bus.redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          word_q[wr_ptr_q] <= bus.imem_rdata;
          pc_q[wr_ptr_q]   <= imem_addr_q;
          wr_ptr_q         <= wr_ptr_q + AW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
      end
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.fq_count  = count_q;
`ifdef IFQ_BYPASS_EN
  assign bus.inst_valid = head_valid || bypass_hit;
  assign bus.inst_word  = bypass_hit ? bus.imem_rdata : word_q[rd_ptr_q];
  assign bus.inst_pc    = bypass_hit ? imem_addr_q    : pc_q[rd_ptr_q];
`else
  assign bus.inst_valid = head_valid;
  assign bus.inst_word  = word_q[rd_ptr_q];
  assign bus.inst_pc    = pc_q[rd_ptr_q];
`endif
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC logic.
- Owns a fetch pointer and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned words, each tagged with its PC, in a small FIFO and presents them to decode with a valid/ready handshake.
- Redirects (taken branch, jump, or register jump) load a new fetch address and flush all in-flight and buffered work.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RESET_ADDR, 32'h00000000, fetch pointer value after reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- redirect  input  1  load redirect_addr and flush; sampled each clk
- redirect_addr  input  32  new fetch address; low 2 bits ignored (forced 0)
- imem_req  output  1  read request to instruction memory
- imem_addr  output  32  word address of the outstanding request
- imem_ack  input  1  one-cycle pulse: imem_rdata valid for the current request
- imem_rdata  input  32  instruction word
- inst_valid  output  1  inst_word/inst_pc valid
- inst_word  output  32  head instruction
- inst_pc  output  32  address of head instruction
- inst_ready  input  1  decode accepts head this cycle
- fq_count  output  clog2(DEPTH)+1  number of buffered entries

Behaviour:
- Reset values: imem_req=0, imem_addr=RESET_ADDR, inst_valid=0, inst_word=0, inst_pc=0, fq_count=0, fetch_ptr=RESET_ADDR, FSM=IDLE.
- Reset mid-transaction: the pending request is abandoned; any imem_ack arriving while reset is asserted is ignored.
- FSM states:
  - IDLE: no request outstanding. If fq_count+0 < DEPTH and redirect=0, next cycle is WAIT with imem_req=1 and imem_addr=fetch_ptr.
  - WAIT: imem_req held high and imem_addr held stable until imem_ack. A request is never withdrawn.
    - On ack with no redirect: push {imem_rdata, imem_addr}; fetch_ptr += 4 (mod 2^32, wraps FFFFFFFC->00000000).
    - After ack: if space remains (accounting for a same-cycle pop), go back-to-back to WAIT with the new address; else go to IDLE with imem_req=0.
  - DISCARD: entered when redirect occurs in WAIT without a same-cycle ack. imem_req stays high with the old address. On ack, data is dropped and the FSM goes to WAIT at the redirected fetch_ptr.
- Redirect effects (same clock edge):
  - fetch_ptr <= {redirect_addr[31:2],2'b00}.
  - FIFO cleared; inst_valid=0 the following cycle.
  - A same-cycle pop is void.
  - Redirect together with ack in WAIT: ack data is dropped, next state is WAIT with the new address.
  - Redirect in IDLE: next state is WAIT with the new address.
  - Redirect in DISCARD: update fetch_ptr only; stay in DISCARD.
- Space rule: a new request is launched only if fq_count < DEPTH after this cycle's pop. A push therefore never overflows, and no ack is lost while full.
- FIFO behaviour:
  - Head is registered: inst_valid=1 iff fq_count>0.
  - Pop occurs when inst_valid & inst_ready.
  - Push and pop in the same cycle: fq_count unchanged, order preserved.
  - Read and write pointers wrap mod DEPTH.
- Latency: imem_ack to inst_valid is 1 cycle, without IFQ_BYPASS_EN.
- Sustained throughput: 1 word/cycle with a 1-cycle memory.
- inst_word/inst_pc hold their values while inst_valid=1 and inst_ready=0.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when the FIFO is empty, FSM=WAIT, imem_ack=1 and redirect=0, inst_valid/inst_word/inst_pc are driven combinationally from imem_rdata/imem_addr in the ack cycle.
  - If inst_ready=1 in that cycle, the word is consumed and not stored.
  - If inst_ready=0, the word is stored as normal.
- Undefined: no combinational path from the imem ports to the inst ports; all inst outputs are registered.

Test Plan:
- Reset release, 1-cycle-ack memory, inst_ready=1 -> imem_addr sequence 0,4,8,C...; inst_pc matches each word one cycle after its ack; fq_count never exceeds 1.
- inst_ready=0, DEPTH=4 -> exactly 4 acks accepted, fq_count=4, imem_req=0. Raise inst_ready -> words pop in order 0,4,8,C and fetching resumes at 0x10.
- Redirect to 0x104 while in WAIT on 0x20, ack 3 cycles later -> 0x20 data dropped; next imem_addr=0x104; first inst_pc=0x104.
- Redirect to 0x200 coincident with ack for 0x08 plus inst_ready=1 with 2 entries queued -> FIFO empty next cycle, 0x08 dropped, next imem_addr=0x200.
- fetch_ptr at 0xFFFFFFF8 -> imem_addr FFFFFFF8, FFFFFFFC, 00000000.
- Assert reset mid-WAIT with an ack in the reset cycle -> all outputs return to reset values and the first request after release is at RESET_ADDR. With IFQ_BYPASS_EN, empty FIFO plus ack 0xDEADBEEF -> inst_word=0xDEADBEEF in the same cycle.
